// File: rtl/yarvis_serial_alu.sv
// rtl/yarvis_serial_alu.sv - byte-serial add/sub/accumulate ALU with valid/ready streams
// Operands arrive little-endian over 8-bit beats; the result streams back the same way.
module yarvis_serial_alu #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic [1:0] op,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       carry,
  output logic       busy
);

  localparam int NBYTES = WIDTH / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_EXEC = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [1:0]       op_q, op_d;
  logic             carry_q, carry_d;

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   acc_w;
  logic [CW+2:0]    base_w;

  assign add_w  = {1'b0, a_q} + {1'b0, b_q};
  assign acc_w  = {1'b0, acc_q} + {1'b0, a_q};
  assign base_w = {cnt_q, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      r_q     <= '0;
      op_q    <= OP_ADD;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      op_q    <= op_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    r_d       = r_q;
    op_d      = op_q;
    carry_d   = carry_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;

    case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cnt_q == '0) begin
            op_d = op;
          end
          // A clear is a single-beat command: its data is dropped and no result follows.
          if (cnt_q == '0 && op == OP_CLR) begin
            acc_d   = '0;
            carry_d = 1'b0;
          end else begin
            a_d[base_w +: 8] = in_a;
            b_d[base_w +: 8] = in_b;
            if (cnt_q == LAST_CNT) begin
              cnt_d   = '0;
              state_d = S_EXEC;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end

      S_EXEC: begin
        case (op_q)
          OP_ADD: begin
            r_d     = add_w[WIDTH-1:0];
            carry_d = add_w[WIDTH];
          end
          OP_SUB: begin
            r_d     = a_q - b_q;
            carry_d = (a_q < b_q);
          end
          OP_ACC: begin
            acc_d   = acc_w[WIDTH-1:0];
            r_d     = acc_w[WIDTH-1:0];
            carry_d = acc_w[WIDTH];
          end
          default: begin
            r_d = r_q;
          end
        endcase
        state_d = S_OUT;
      end

      S_OUT: begin
        out_valid = 1'b1;
        out_data  = r_q[base_w +: 8];
        out_last  = (cnt_q == LAST_CNT);
        if (out_ready) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = S_LOAD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  assign carry = carry_q;
  assign busy  = !(state_q == S_LOAD && cnt_q == '0);

endmodule

// File: tb/tb_yarvis_serial_alu.sv
// tb/tb_yarvis_serial_alu.sv - directed table-driven bench for yarvis_serial_alu
// Instance 0 is WIDTH=16, instance 1 is WIDTH=8, instance 2 is WIDTH=32.
module tb_yarvis_serial_alu;

  logic       clk;
  logic       rst_n;
  logic [2:0] iv;
  logic [2:0] ordy;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [1:0] op;
  wire  [2:0] ir;
  wire  [2:0] ov;
  wire  [2:0] ol;
  wire  [2:0] cy;
  wire  [2:0] bz;
  wire  [7:0] od [0:2];

  int pass_cnt;
  int total_cnt;

  yarvis_serial_alu #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_a(in_a), .in_b(in_b), .op(op), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(od[0]), .out_last(ol[0]), .carry(cy[0]), .busy(bz[0])
  );

  yarvis_serial_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_a(in_a), .in_b(in_b), .op(op), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(od[1]), .out_last(ol[1]), .carry(cy[1]), .busy(bz[1])
  );

  yarvis_serial_alu #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_a(in_a), .in_b(in_b), .op(op), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_data(od[2]), .out_last(ol[2]), .carry(cy[2]), .busy(bz[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          d;
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        c;
    string       nm;
  } vec_t;

  vec_t tv [$];

  function automatic int nbytes(input int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic txn(input int d, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] r, input logic c,
                     input string nm);
    int          nb;
    int          w;
    logic [31:0] got;
    logic [31:0] tmp_a;
    logic [31:0] tmp_b;
    nb    = (o == 2'b11) ? 1 : nbytes(d);
    got   = '0;
    tmp_a = a;
    tmp_b = b;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      op    = o;
      in_a  = tmp_a[8*i +: 8];
      in_b  = tmp_b[8*i +: 8];
      iv[d] = 1'b1;
      if (i == 0) chk({nm, " in_ready"}, 32'(ir[d]), 32'd1);
    end
    @(negedge clk);
    iv[d] = 1'b0;
    if (o == 2'b11) begin
      chk({nm, " clr busy"}, 32'(bz[d]), 32'd0);
      chk({nm, " clr carry"}, 32'(cy[d]), 32'd0);
      chk({nm, " clr no out"}, 32'(ov[d]), 32'd0);
      return;
    end
    ordy[d] = 1'b1;
    for (int i = 0; i < nbytes(d); i++) begin
      w = 0;
      while (ov[d] !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (ov[d] !== 1'b1) begin
        chk($sformatf("%s timeout byte%0d", nm, i), 32'(ov[d]), 32'd1);
        break;
      end
      chk($sformatf("%s last%0d", nm, i), 32'(ol[d]), 32'(i == nbytes(d) - 1));
      got[8*i +: 8] = od[d];
      @(negedge clk);
    end
    ordy[d] = 1'b0;
    chk({nm, " result"}, got, r);
    chk({nm, " carry"}, 32'(cy[d]), 32'(c));
    chk({nm, " idle"}, 32'(bz[d]), 32'd0);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    iv    = '0;
    ordy  = '0;
    in_a  = '0;
    in_b  = '0;
    op    = '0;

    tv.push_back('{0, 2'b00, 32'h1234, 32'h0F0F, 32'h2143, 1'b0, "add16 basic"});
    tv.push_back('{0, 2'b00, 32'hFFFF, 32'h0001, 32'h0000, 1'b1, "add16 wrap"});
    tv.push_back('{0, 2'b01, 32'h0001, 32'h0002, 32'hFFFF, 1'b1, "sub16 borrow"});
    tv.push_back('{0, 2'b01, 32'h0005, 32'h0003, 32'h0002, 1'b0, "sub16 plain"});
    tv.push_back('{0, 2'b11, 32'h00AA, 32'h0055, 32'h0000, 1'b0, "clr16 a"});
    tv.push_back('{0, 2'b10, 32'h8000, 32'h1111, 32'h8000, 1'b0, "acc16 first"});
    tv.push_back('{0, 2'b10, 32'h8000, 32'h2222, 32'h0000, 1'b1, "acc16 wrap"});
    tv.push_back('{0, 2'b10, 32'h1234, 32'h0000, 32'h1234, 1'b0, "acc16 third"});
    tv.push_back('{0, 2'b00, 32'h00FF, 32'h0001, 32'h0100, 1'b0, "add16 bytecarry"});
    tv.push_back('{0, 2'b01, 32'h0000, 32'h0000, 32'h0000, 1'b0, "sub16 zero"});
    tv.push_back('{0, 2'b11, 32'h0000, 32'h0000, 32'h0000, 1'b0, "clr16 b"});
    tv.push_back('{0, 2'b10, 32'h0001, 32'h0000, 32'h0001, 1'b0, "acc16 after clr"});
    tv.push_back('{1, 2'b00, 32'hFF, 32'h01, 32'h00, 1'b1, "add8 wrap"});
    tv.push_back('{1, 2'b00, 32'h12, 32'h34, 32'h46, 1'b0, "add8 plain"});
    tv.push_back('{1, 2'b01, 32'h10, 32'h20, 32'hF0, 1'b1, "sub8 borrow"});
    tv.push_back('{2, 2'b00, 32'h89ABCDEF, 32'h76543211, 32'h00000000, 1'b1, "add32 wrap"});
    tv.push_back('{2, 2'b01, 32'h12345678, 32'h02040608, 32'h10305070, 1'b0, "sub32 plain"});

    #2;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset in_ready%0d", d), 32'(ir[d]), 32'd1);
      chk($sformatf("reset out_valid%0d", d), 32'(ov[d]), 32'd0);
      chk($sformatf("reset out_data%0d", d), 32'(od[d]), 32'd0);
      chk($sformatf("reset out_last%0d", d), 32'(ol[d]), 32'd0);
      chk($sformatf("reset carry%0d", d), 32'(cy[d]), 32'd0);
      chk($sformatf("reset busy%0d", d), 32'(bz[d]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[k]) txn(tv[k].d, tv[k].o, tv[k].a, tv[k].b, tv[k].r, tv[k].c, tv[k].nm);

    // Latency and back-pressure on the 16-bit instance.
    @(negedge clk);
    op = 2'b00; in_a = 8'h34; in_b = 8'h0F; iv[0] = 1'b1;
    @(negedge clk);
    in_a = 8'h12; in_b = 8'h0F;
    @(negedge clk);
    iv[0] = 1'b0;
    chk("lat exec out_valid", 32'(ov[0]), 32'd0);
    chk("lat exec in_ready", 32'(ir[0]), 32'd0);
    chk("lat exec busy", 32'(bz[0]), 32'd1);
    @(negedge clk);
    chk("lat out_valid", 32'(ov[0]), 32'd1);
    chk("lat out_data", 32'(od[0]), 32'h43);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp hold data%0d", i), 32'(od[0]), 32'h43);
      chk($sformatf("bp hold valid%0d", i), 32'(ov[0]), 32'd1);
      chk($sformatf("bp in_ready%0d", i), 32'(ir[0]), 32'd0);
      chk($sformatf("bp last%0d", i), 32'(ol[0]), 32'd0);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("bp byte1 data", 32'(od[0]), 32'h21);
    chk("bp byte1 last", 32'(ol[0]), 32'd1);
    chk("bp byte1 valid", 32'(ov[0]), 32'd1);
    @(negedge clk);
    ordy[0] = 1'b0;
    chk("bp done valid", 32'(ov[0]), 32'd0);
    chk("bp done in_ready", 32'(ir[0]), 32'd1);

    // Reset after one of two operand beats must discard the partial operand.
    @(negedge clk);
    op = 2'b00; in_a = 8'h77; in_b = 8'h66; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    chk("midrst busy before", 32'(bz[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready", 32'(ir[0]), 32'd1);
    chk("midrst busy", 32'(bz[0]), 32'd0);
    chk("midrst carry", 32'(cy[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    txn(0, 2'b00, 32'h0002, 32'h0003, 32'h0005, 1'b0, "post reset add");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
